// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor front end.
//   fetch_state_e      : fetch FSM state encoding
//   HALT_INSTR         : reserved encoding that stops fetch when FETCH_HALT_EN is defined
//   DEFAULT_RESET_PC   : default program counter after reset
//   wait_cnt_width()   : width of the memory-latency wait counter
package cpu_pkg;

   localparam logic [15:0] HALT_INSTR       = 16'hF0F0;
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StIssue,
      StHalted
   } fetch_state_e;

   // The counter is loaded with lat-2 and counts down to zero.
   function automatic int unsigned wait_cnt_width(input int unsigned lat);
      return (lat > 2) ? $clog2(lat - 1) : 1;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   imem_addr : read address driven by the fetch unit
//   imem_data : read data returned by the memory
// Modports: master (fetch unit side), slave (memory side).
interface fetch_unit_if #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ADDR_WIDTH = 16
);

   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0]      imem_data;

   modport master (
      output imem_addr,
      input  imem_data
   );

   modport slave (
      input  imem_addr,
      output imem_data
   );

endinterface

// File: rtl/fetch_unit_reg.sv
// Generic enabled register with synchronous active-high reset.
//   clk_i   : clock, rising edge
//   reset_i : synchronous reset, loads RESET_VAL
//   en_i    : capture enable
//   d_i     : data in
//   q_o     : registered data out
module fetch_unit_reg #(
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         q_q <= RESET_VAL;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, presents it on the instruction-memory bus, waits out
// the memory latency and pulses ir_en_o for one cycle per issued instruction.
//   clk_i        : clock, rising edge
//   reset_i      : synchronous active-high reset
//   stall_i      : hold the fetched instruction in ISSUE, do not issue
//   pc_load_i    : redirect the PC to pc_target_i (wins over issue and stall)
//   pc_target_i  : redirect address
//   imem_bus     : instruction-memory read bus (master modport)
//   instr_o      : imem data passed through to the IR
//   ir_en_o      : IR capture enable, one pulse per issued instruction
//   instr_pc_o   : address of the most recently issued instruction
//   halted_o     : fetch stopped on HALT_INSTR
// Optional feature: define FETCH_HALT_EN to stop fetching after HALT_INSTR is issued.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned           WIDTH       = 16,
   parameter int unsigned           ADDR_WIDTH  = 16,
   parameter int unsigned           MEM_LATENCY = 1,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  stall_i,
   input  logic                  pc_load_i,
   input  logic [ADDR_WIDTH-1:0] pc_target_i,
   fetch_unit_if.master          imem_bus,
   output logic [WIDTH-1:0]      instr_o,
   output logic                  ir_en_o,
   output logic [ADDR_WIDTH-1:0] instr_pc_o,
   output logic                  halted_o
);

   localparam int unsigned     CntW    = wait_cnt_width(MEM_LATENCY);
   localparam logic [CntW-1:0] CntLoad = CntW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

   fetch_state_e          state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [CntW-1:0]       wait_cnt_q;
   logic                  halted_q;
   logic                  redirect;
   logic                  issue;

   // pc_load is ignored only in IDLE, which lasts exactly one cycle after reset.
   assign redirect = pc_load_i && (state_q != StIdle);
   // Issue needs valid data, no stall, and no redirect taking precedence.
   assign issue    = (state_q == StIssue) && !stall_i && !pc_load_i;

`ifdef FETCH_HALT_EN
   logic is_halt;
   assign is_halt = (imem_bus.imem_data == WIDTH'(HALT_INSTR));
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         wait_cnt_q <= '0;
         halted_q   <= 1'b0;
      end else if (redirect) begin
         // Any in-flight fetch is dropped; the new address starts a fresh request.
         state_q  <= StReq;
         pc_q     <= pc_target_i;
         halted_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_q <= StReq;
            end
            StReq: begin
               if (MEM_LATENCY > 1) begin
                  state_q    <= StWait;
                  wait_cnt_q <= CntLoad;
               end else begin
                  state_q <= StIssue;
               end
            end
            StWait: begin
               if (wait_cnt_q == '0) begin
                  state_q <= StIssue;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
            StIssue: begin
               // While stalled, pc (and so imem_addr) is held so the data stays valid.
               if (!stall_i) begin
                  pc_q    <= pc_q + 1'b1;
                  state_q <= StReq;
`ifdef FETCH_HALT_EN
                  if (is_halt) begin
                     state_q  <= StHalted;
                     halted_q <= 1'b1;
                  end
`endif
               end
            end
`ifdef FETCH_HALT_EN
            StHalted: begin
               state_q <= StHalted;
            end
`endif
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // instr_pc resets to zero independent of RESET_PC.
   fetch_unit_reg #(
      .WIDTH     (ADDR_WIDTH),
      .RESET_VAL ('0)
   ) u_instr_pc_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (issue),
      .d_i     (pc_q),
      .q_o     (instr_pc_o)
   );

   assign imem_bus.imem_addr = pc_q;
   assign instr_o            = imem_bus.imem_data;
   assign ir_en_o            = issue;
   assign halted_o           = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (memory latency 1 and 3), a latency-accurate memory
// model, a cycle-level reference model and directed scenarios with literal expectations.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int unsigned ML0 = 1;
   localparam int unsigned ML1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_s    [2];
   logic        stall_s    [2];
   logic        pc_load_s  [2];
   logic [15:0] pc_target_s[2];
   logic [15:0] instr_w    [2];
   logic [15:0] instr_pc_w [2];
   logic [15:0] addr_w     [2];
   logic        ir_en_w    [2];
   logic        halted_w   [2];

   int n_cmp = 0;
   int n_bad = 0;
   int halt_at = -1;

   fetch_unit_if #(.WIDTH(16), .ADDR_WIDTH(16)) bus0 ();
   fetch_unit_if #(.WIDTH(16), .ADDR_WIDTH(16)) bus1 ();

   fetch_unit #(.MEM_LATENCY(ML0)) dut0 (
      .clk_i(clk), .reset_i(reset_s[0]), .stall_i(stall_s[0]), .pc_load_i(pc_load_s[0]),
      .pc_target_i(pc_target_s[0]), .imem_bus(bus0), .instr_o(instr_w[0]),
      .ir_en_o(ir_en_w[0]), .instr_pc_o(instr_pc_w[0]), .halted_o(halted_w[0])
   );

   fetch_unit #(.MEM_LATENCY(ML1)) dut1 (
      .clk_i(clk), .reset_i(reset_s[1]), .stall_i(stall_s[1]), .pc_load_i(pc_load_s[1]),
      .pc_target_i(pc_target_s[1]), .imem_bus(bus1), .instr_o(instr_w[1]),
      .ir_en_o(ir_en_w[1]), .instr_pc_o(instr_pc_w[1]), .halted_o(halted_w[1])
   );

   assign addr_w[0] = bus0.imem_addr;
   assign addr_w[1] = bus1.imem_addr;

   // Memory contents: word k = 16'h1000 + k, optionally HALT_INSTR at address h.
   function automatic logic [15:0] mem_word(input logic [15:0] a, input int h);
      if (h >= 0 && int'(a) == h) return HALT_INSTR;
      return 16'h1000 + a;
   endfunction

   // Read data reflects the address presented ML cycles earlier.
   logic [15:0] hist0;
   logic [15:0] hist1[3];
   always @(posedge clk) begin
      hist0    <= bus0.imem_addr;
      hist1[0] <= bus1.imem_addr;
      hist1[1] <= hist1[0];
      hist1[2] <= hist1[1];
   end
   assign bus0.imem_data = mem_word(hist0, halt_at);
   assign bus1.imem_data = mem_word(hist1[2], halt_at);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: per instance, the address being fetched, how many cycles it has been
   // on the bus (saturating at the latency), and the last issued address.
   int          lat    [2] = '{ML0, ML1};
   logic        m_valid[2] = '{1'b0, 1'b0};
   logic        m_idle [2];
   logic        m_halt [2];
   logic [15:0] m_pc   [2];
   logic [15:0] m_ipc  [2];
   int          m_age  [2];

   always @(negedge clk) begin
      logic exp_ir;
      for (int i = 0; i < 2; i++) begin
         exp_ir = 1'b0;
         if (m_valid[i]) begin
            exp_ir = !m_idle[i] && !m_halt[i] && (m_age[i] >= lat[i]) && !stall_s[i] &&
                     !pc_load_s[i];
            chk($sformatf("model%0d imem_addr", i), addr_w[i], m_pc[i]);
            chk($sformatf("model%0d ir_en", i), ir_en_w[i], exp_ir);
            chk($sformatf("model%0d instr_pc", i), instr_pc_w[i], m_ipc[i]);
            chk($sformatf("model%0d halted", i), halted_w[i], m_halt[i]);
            if (exp_ir) chk($sformatf("model%0d instr", i), instr_w[i],
                            mem_word(m_pc[i], halt_at));
         end
         // Advance to the state after the coming rising edge.
         if (reset_s[i]) begin
            m_valid[i] = 1'b1;
            m_idle[i]  = 1'b1;
            m_halt[i]  = 1'b0;
            m_pc[i]    = 16'h0000;
            m_ipc[i]   = 16'h0000;
            m_age[i]   = 0;
         end else if (m_valid[i]) begin
            if (m_idle[i]) begin
               m_idle[i] = 1'b0;
               m_age[i]  = 0;
            end else if (pc_load_s[i]) begin
               m_pc[i]   = pc_target_s[i];
               m_age[i]  = 0;
               m_halt[i] = 1'b0;
            end else if (m_halt[i]) begin
               m_age[i] = 0;
            end else if (exp_ir) begin
               m_ipc[i] = m_pc[i];
`ifdef FETCH_HALT_EN
               if (mem_word(m_pc[i], halt_at) == HALT_INSTR) m_halt[i] = 1'b1;
`endif
               m_pc[i]  = m_pc[i] + 16'd1;
               m_age[i] = 0;
            end else if (m_age[i] < lat[i]) begin
               m_age[i] = m_age[i] + 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts negedges until ir_en is seen; an expired budget is a failed comparison.
   task automatic wait_ir(input int i, input int budget, output int n);
      for (n = 1; n <= budget; n++) begin
         @(negedge clk);
         if (ir_en_w[i]) return;
      end
      chk($sformatf("dut%0d ir_en within %0d cycles", i, budget), ir_en_w[i], 1'b1);
   endtask

   // Leaves the caller at the start of the first cycle with reset low (the IDLE cycle).
   task automatic do_reset(input int i);
      step();
      reset_s[i]   = 1'b1;
      stall_s[i]   = 1'b0;
      pc_load_s[i] = 1'b0;
      step();
      step();
      reset_s[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 2; i++) begin
         reset_s[i]     = 1'b1;
         stall_s[i]     = 1'b0;
         pc_load_s[i]   = 1'b0;
         pc_target_s[i] = 16'h0000;
      end
      repeat (3) step();
      reset_s[0] = 1'b0;
      reset_s[1] = 1'b0;

      // ---- latency 1: basic stream, stall, redirect, wrap ----
      do_reset(0);
      chk("dut0 reset imem_addr", addr_w[0], 16'h0000);
      wait_ir(0, 10, n);
      chk("dut0 first ir_en cycle", n, 3);   // IDLE, REQ, ISSUE
      chk("dut0 instr k0", instr_w[0], 16'h1000);
      chk("dut0 instr_pc before first", instr_pc_w[0], 16'h0000);
      wait_ir(0, 10, n);
      chk("dut0 ir_en gap 1", n, 2);
      chk("dut0 instr k1", instr_w[0], 16'h1001);
      wait_ir(0, 10, n);
      chk("dut0 ir_en gap 2", n, 2);
      chk("dut0 instr k2", instr_w[0], 16'h1002);
      @(negedge clk);
      chk("dut0 instr_pc k2", instr_pc_w[0], 16'h0002);

      wait_ir(0, 4, n);                       // ISSUE of addr 3
      step();
      stall_s[0] = 1'b1;                      // REQ of addr 4, then 5 stalled ISSUE cycles
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("dut0 stall no ir_en", ir_en_w[0], 1'b0);
         chk("dut0 stall addr held", addr_w[0], 16'h0004);
         step();
      end
      stall_s[0] = 1'b0;
      @(negedge clk);
      chk("dut0 stall release ir_en", ir_en_w[0], 1'b1);
      chk("dut0 stall release instr", instr_w[0], 16'h1004);
      step();
      @(negedge clk);
      chk("dut0 after stall addr", addr_w[0], 16'h0005);

      wait_ir(0, 4, n);                       // addr 5
      wait_ir(0, 4, n);                       // addr 6
      step();                                 // REQ addr 7
      step();                                 // ISSUE addr 7
      pc_load_s[0]   = 1'b1;
      pc_target_s[0] = 16'h0040;
      @(negedge clk);
      chk("dut0 redirect kills ir_en", ir_en_w[0], 1'b0);
      step();
      pc_load_s[0] = 1'b0;
      @(negedge clk);
      chk("dut0 redirect addr", addr_w[0], 16'h0040);
      wait_ir(0, 4, n);
      chk("dut0 redirect latency", n, 1);
      chk("dut0 redirect instr", instr_w[0], 16'h1040);
      step();
      @(negedge clk);
      chk("dut0 redirect instr_pc", instr_pc_w[0], 16'h0040);

      step();
      pc_load_s[0]   = 1'b1;
      pc_target_s[0] = 16'hFFFF;
      step();
      pc_load_s[0] = 1'b0;
      wait_ir(0, 4, n);
      chk("dut0 wrap instr", instr_w[0], 16'h0FFF);
      step();
      @(negedge clk);
      chk("dut0 wrap addr", addr_w[0], 16'h0000);
      chk("dut0 wrap instr_pc", instr_pc_w[0], 16'hFFFF);

      // ---- HALT word at address 3 ----
      do_reset(0);
      halt_at = 3;
      for (int k = 0; k < 4; k++) wait_ir(0, 4, n);
      chk("dut0 halt word issued", instr_w[0], 16'hF0F0);
`ifdef FETCH_HALT_EN
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("dut0 halted", halted_w[0], 1'b1);
         chk("dut0 halted no ir_en", ir_en_w[0], 1'b0);
         chk("dut0 halted pc", addr_w[0], 16'h0004);
      end
      step();
      pc_load_s[0]   = 1'b1;
      pc_target_s[0] = 16'h0000;
      step();
      pc_load_s[0] = 1'b0;
      @(negedge clk);
      chk("dut0 halt exit halted", halted_w[0], 1'b0);
      chk("dut0 halt exit addr", addr_w[0], 16'h0000);
      wait_ir(0, 4, n);
      chk("dut0 resume instr", instr_w[0], 16'h1000);
`else
      wait_ir(0, 4, n);
      chk("dut0 no-halt next instr", instr_w[0], 16'h1004);
      chk("dut0 no-halt halted", halted_w[0], 1'b0);
`endif
      step();
      halt_at = -1;

      // ---- latency 3: stream, reset mid-WAIT, redirect in WAIT, stall+redirect ----
      do_reset(1);
      wait_ir(1, 12, n);
      chk("dut1 first ir_en cycle", n, 5);   // IDLE, REQ, WAIT, WAIT, ISSUE
      chk("dut1 instr k0", instr_w[1], 16'h1000);
      wait_ir(1, 12, n);
      chk("dut1 ir_en gap", n, 4);
      chk("dut1 instr k1", instr_w[1], 16'h1001);
      step();                                 // REQ addr 2
      step();                                 // WAIT
      reset_s[1] = 1'b1;
      @(negedge clk);
      chk("dut1 wait no ir_en", ir_en_w[1], 1'b0);
      step();
      @(negedge clk);
      chk("dut1 mid-wait reset addr", addr_w[1], 16'h0000);
      chk("dut1 mid-wait reset instr_pc", instr_pc_w[1], 16'h0000);
      chk("dut1 mid-wait reset ir_en", ir_en_w[1], 1'b0);
      step();
      reset_s[1] = 1'b0;
      wait_ir(1, 12, n);
      chk("dut1 post-reset ir_en cycle", n, 5);
      chk("dut1 post-reset instr", instr_w[1], 16'h1000);

      step();                                 // REQ addr 1
      step();                                 // WAIT
      pc_load_s[1]   = 1'b1;
      pc_target_s[1] = 16'h0020;
      step();
      pc_load_s[1] = 1'b0;
      wait_ir(1, 12, n);
      chk("dut1 wait redirect latency", n, 4);
      chk("dut1 wait redirect instr", instr_w[1], 16'h1020);

      step();                                 // REQ 0x21
      step();
      step();
      step();                                 // ISSUE 0x21
      stall_s[1]     = 1'b1;
      pc_load_s[1]   = 1'b1;
      pc_target_s[1] = 16'h0030;
      @(negedge clk);
      chk("dut1 redirect over stall ir_en", ir_en_w[1], 1'b0);
      step();
      stall_s[1]   = 1'b0;
      pc_load_s[1] = 1'b0;
      wait_ir(1, 12, n);
      chk("dut1 redirect over stall latency", n, 4);
      chk("dut1 redirect over stall instr", instr_w[1], 16'h1030);

      repeat (4) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit processor. Owns the program counter, drives the instruction-memory address, waits out the memory read latency, and presents each fetched word to the instruction register with a one-cycle capture enable. It accepts a PC redirect from the branch/jump logic and a stall from the control FSM. It sits directly upstream of the instruction register.

## Interface
- WIDTH, 16, instruction word width
- ADDR_WIDTH, 16, instruction-memory address / PC width
- MEM_LATENCY, 1, cycles from address presented to data valid (≥1)
- RESET_PC, 0, PC value after reset
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold the fetched instruction; do not issue
- pc_load  in  1  redirect the PC (taken branch/jump)
- pc_target  in  ADDR_WIDTH  redirect address
- imem_addr  out  ADDR_WIDTH  instruction-memory read address (equals pc)
- imem_data  in  WIDTH  instruction-memory read data
- instr  out  WIDTH  instruction to the IR (combinational copy of imem_data)
- ir_en  out  1  IR capture enable, one-cycle pulse per issued instruction
- instr_pc  out  ADDR_WIDTH  address of the most recently issued instruction
- halted  out  1  fetch stopped on HALT (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, ISSUE, HALTED.
- Reset (any state, any cycle): state=IDLE, pc=RESET_PC, wait counter=0, instr_pc=0, ir_en=0, halted=0. imem_addr=RESET_PC.
- IDLE → REQ unconditionally (one cycle).
- REQ: imem_addr=pc valid. Next: WAIT if MEM_LATENCY>1 (counter loaded MEM_LATENCY-2), else ISSUE.
- WAIT: counter decrements; at 0 → ISSUE.
- ISSUE: imem_data valid. If stall=0: ir_en=1, instr_pc←pc, pc←pc+1 (wraps modulo 2^ADDR_WIDTH), → REQ. If stall=1: ir_en=0, remain in ISSUE, pc and imem_addr held, so data stays valid.
- pc_load=1 in REQ/WAIT/ISSUE: pc←pc_target, → REQ, in-flight fetch discarded, ir_en forced 0 that cycle (redirect wins over issue and over stall).
- pc_load in IDLE: ignored (IDLE lasts one cycle after reset).
- imem_addr always equals pc; held stable from REQ through ISSUE.
- instr is imem_data passed through; meaningful only when ir_en=1.

## Timing
- Fetch latency: REQ in cycle N, ir_en in cycle N+MEM_LATENCY.
- Throughput: one instruction per MEM_LATENCY+1 cycles, no stall.
- After reset deasserts at edge E: IDLE in cycle E, REQ in E+1, first ir_en in E+1+MEM_LATENCY.
- IR captures instr on the rising edge ending the ir_en cycle.
- Redirect: pc_load in cycle N → REQ of pc_target in N+1; next ir_en no earlier than N+1+MEM_LATENCY.
- Stall released in cycle N (stall=0 in ISSUE) → ir_en=1 in N, same cycle.

## Configuration
- FETCH_HALT_EN defined: in ISSUE with stall=0 and instr==HALT_INSTR, the HALT word is issued normally (ir_en=1, instr_pc updated), pc increments, then state → HALTED. HALTED: halted=1, ir_en=0, no fetch, pc held. Exit only via reset (→ IDLE) or pc_load (→ REQ, halted←0).
- Not defined: HALTED state absent, halted tied 0, HALT_INSTR fetched as an ordinary word.

## Structure
- Shared package cpu_pkg: state encoding, HALT_INSTR (16'hF0F0, reserved encoding), default RESET_PC.
- instr_pc is held in one instance of the codebase's register module (width ADDR_WIDTH, enable=ir_en). The FSM, PC and wait counter live in fetch_unit.

## Test plan
- Reset, MEM_LATENCY=1, memory word k = 16'h1000+k → ir_en every 2nd cycle; instr 16'h1000, 16'h1001, 16'h1002; instr_pc 0,1,2.
- MEM_LATENCY=3, no stall → ir_en every 4th cycle; first ir_en 4 cycles after reset deassertion.
- stall high 5 cycles during ISSUE of addr 4 → ir_en stays 0, imem_addr stays 4; ir_en=1 in the cycle stall falls; next fetch is addr 5.
- pc_load=1, pc_target=16'h0040 in the same cycle as ISSUE of addr 7 → no ir_en for addr 7; next issued instr_pc=16'h0040.
- pc=16'hFFFF issued → next imem_addr=16'h0000. Reset asserted mid-WAIT → IDLE, imem_addr=RESET_PC, no ir_en.
- FETCH_HALT_EN defined, HALT_INSTR at addr 3 → ir_en for addr 3, then halted=1 and no ir_en; pc_load to 0 → halted=0 and fetch resumes at 0.
